// File: rtl/cmos_16_8bit_tx.sv
// cmos_16_8bit_tx: transmit-side pixel serializer.
// Accepts 16-bit pixels through valid/ready into a small FIFO and emits a
// CMOS/DVP-style 8-bit byte stream qualified by de_o (HREF), two pclk cycles
// per pixel. Each line is H_ACTIVE pixels, then H_BLANK cycles of hblank,
// then one IDLE cycle before the next line can start.
//
// Ports:
//   pclk        clock, rising edge
//   rst         asynchronous active-high reset
//   pdata_i     input pixel, [15:8] = high byte
//   valid_i     pdata_i valid
//   ready_o     FIFO not full (from registered occupancy only)
//   pdata_o     output byte (registered, holds while de_o=0)
//   de_o        byte valid / HREF (registered)
//   hblank      high during horizontal blanking (registered)
//   line_end_o  pulse on the last byte of a line (registered)
//   underrun_o  sticky: FIFO empty at a mid-line pixel boundary
//
// Build option: define CMOS_TX_LOW_BYTE_FIRST_EN to send pdata_i[7:0] first;
// by default the high byte goes first.
module cmos_16_8bit_tx #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_BLANK    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [15:0] pdata_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [7:0]  pdata_o,
  output logic        de_o,
  output logic        hblank,
  output logic        line_end_o,
  output logic        underrun_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BC_W  = $clog2(2 * H_ACTIVE);
  localparam int unsigned BL_W  = $clog2(H_BLANK + 1);

  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(2 * H_ACTIVE - 1);
  localparam logic [BL_W-1:0]  BLANK_END = BL_W'(H_BLANK);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK} state_t;

  // ---------------- input FIFO ----------------
  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             empty;
  logic [15:0]      head;
  logic [7:0]       first_byte;
  logic [7:0]       second_byte;

  assign ready_o = (count != FULL_CNT);
  assign empty   = (count == '0);
  assign push    = valid_i && ready_o;
  assign head    = mem[rd_ptr];

`ifdef CMOS_TX_LOW_BYTE_FIRST_EN
  assign first_byte  = head[7:0];
  assign second_byte = head[15:8];
`else
  assign first_byte  = head[15:8];
  assign second_byte = head[7:0];
`endif

  // Pointers and occupancy; push+pop together leaves count unchanged.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= pdata_i;
  end

  // ---------------- line FSM ----------------
  state_t          state, state_nxt;
  logic            phase, phase_nxt;
  logic [BC_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [BL_W-1:0] blank_cnt, blank_cnt_nxt;
  logic [7:0]      hold, hold_nxt;
  logic [7:0]      pdata_nxt;
  logic            de_nxt;
  logic            hblank_nxt;
  logic            line_end_nxt;
  logic            underrun_nxt;

  // State and registered outputs.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      phase      <= 1'b0;
      byte_cnt   <= '0;
      blank_cnt  <= '0;
      hold       <= '0;
      pdata_o    <= '0;
      de_o       <= 1'b0;
      hblank     <= 1'b0;
      line_end_o <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      byte_cnt   <= byte_cnt_nxt;
      blank_cnt  <= blank_cnt_nxt;
      hold       <= hold_nxt;
      pdata_o    <= pdata_nxt;
      de_o       <= de_nxt;
      hblank     <= hblank_nxt;
      line_end_o <= line_end_nxt;
      underrun_o <= underrun_nxt;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    byte_cnt_nxt  = byte_cnt;
    blank_cnt_nxt = blank_cnt;
    hold_nxt      = hold;
    pdata_nxt     = pdata_o;
    de_nxt        = 1'b0;
    hblank_nxt    = 1'b0;
    line_end_nxt  = 1'b0;
    underrun_nxt  = underrun_o;
    pop           = 1'b0;

    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          pdata_nxt    = first_byte;
          hold_nxt     = second_byte;
          de_nxt       = 1'b1;
          phase_nxt    = 1'b1;
          byte_cnt_nxt = BC_W'(1);
          state_nxt    = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (phase) begin
          pdata_nxt = hold;
          de_nxt    = 1'b1;
          phase_nxt = 1'b0;
          if (byte_cnt == LAST_BYTE) begin
            line_end_nxt = 1'b1;
            byte_cnt_nxt = '0;
            state_nxt    = S_BLANK;
          end else begin
            byte_cnt_nxt = byte_cnt + BC_W'(1);
          end
        end else if (!empty) begin
          pop          = 1'b1;
          pdata_nxt    = first_byte;
          hold_nxt     = second_byte;
          de_nxt       = 1'b1;
          phase_nxt    = 1'b1;
          byte_cnt_nxt = byte_cnt + BC_W'(1);
        end else begin
          // Starved at a pixel boundary: stall the line, hold pdata_o.
          underrun_nxt = 1'b1;
        end
      end
      S_BLANK: begin
        // H_BLANK cycles of hblank, then one dead cycle shown during IDLE.
        if (blank_cnt == BLANK_END) begin
          blank_cnt_nxt = '0;
          state_nxt     = S_IDLE;
        end else begin
          hblank_nxt    = 1'b1;
          blank_cnt_nxt = blank_cnt + BL_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmos_16_8bit_tx.sv
// Bench for cmos_16_8bit_tx: a 640-pixel instance checked through a byte
// scoreboard plus a line-framing model, and a 1-pixel-line instance for the
// single-pixel latency and byte-order checks.
`timescale 1ns/1ps
module tb_cmos_16_8bit_tx;

  localparam int H_ACTIVE   = 640;
  localparam int H_BLANK    = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int LINE_BYTES = 2 * H_ACTIVE;

  logic        pclk = 1'b0;
  logic        rst;
  logic [15:0] pdata_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  pdata_o;
  logic        de_o;
  logic        hblank;
  logic        line_end_o;
  logic        underrun_o;

  logic [15:0] one_pdata_i;
  logic        one_valid_i;
  logic        one_ready;
  logic [7:0]  one_pdata;
  logic        one_de;
  logic        one_hblank;
  logic        one_line_end;
  logic        one_underrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 pclk = ~pclk;

  cmos_16_8bit_tx #(.H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .FIFO_DEPTH(FIFO_DEPTH)) u_dut (
    .pclk(pclk), .rst(rst), .pdata_i(pdata_i), .valid_i(valid_i), .ready_o(ready_o),
    .pdata_o(pdata_o), .de_o(de_o), .hblank(hblank), .line_end_o(line_end_o),
    .underrun_o(underrun_o)
  );

  cmos_16_8bit_tx #(.H_ACTIVE(1), .H_BLANK(H_BLANK), .FIFO_DEPTH(FIFO_DEPTH)) u_one (
    .pclk(pclk), .rst(rst), .pdata_i(one_pdata_i), .valid_i(one_valid_i), .ready_o(one_ready),
    .pdata_o(one_pdata), .de_o(one_de), .hblank(one_hblank), .line_end_o(one_line_end),
    .underrun_o(one_underrun)
  );

  function automatic logic [7:0] byte_a(input logic [15:0] w);
`ifdef CMOS_TX_LOW_BYTE_FIRST_EN
    return w[7:0];
`else
    return w[15:8];
`endif
  endfunction

  function automatic logic [7:0] byte_b(input logic [15:0] w);
`ifdef CMOS_TX_LOW_BYTE_FIRST_EN
    return w[15:8];
`else
    return w[7:0];
`endif
  endfunction

  // Scoreboard and line-framing model for u_dut.
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  logic [7:0] last_byte = 8'h00;
  int  line_byte  = 0;
  int  blank_left = 0;
  int  lines_done = 0;
  bit  gap_next   = 1'b0;
  bit  allow_gap  = 1'b0;

  always @(negedge pclk) begin
    if (rst) begin
      exp_q.delete();
      line_byte  = 0;
      blank_left = 0;
      gap_next   = 1'b0;
      last_byte  = 8'h00;
    end else begin
      vectors++;
      if (hblank !== (blank_left != 0)) begin
        miscompares++;
        $display("FAIL hblank: got %b, want %b (blank_left=%0d)", hblank, (blank_left != 0), blank_left);
      end
      if (blank_left != 0 || gap_next) begin
        vectors++;
        if (de_o !== 1'b0 || line_end_o !== 1'b0) begin
          miscompares++;
          $display("FAIL blank_de: got de=%b line_end=%b, want 0/0", de_o, line_end_o);
        end
        if (blank_left != 0) begin
          blank_left--;
          gap_next = (blank_left == 0);
        end else begin
          gap_next = 1'b0;
        end
      end else if (de_o === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_byte: got %h, want no byte", pdata_o);
        end else begin
          exp_byte = exp_q.pop_front();
          if (pdata_o !== exp_byte) begin
            miscompares++;
            $display("FAIL byte[%0d]: got %h, want %h", line_byte, pdata_o, exp_byte);
          end
        end
        vectors++;
        if (line_end_o !== (line_byte == LINE_BYTES - 1)) begin
          miscompares++;
          $display("FAIL line_end[%0d]: got %b, want %b", line_byte, line_end_o, (line_byte == LINE_BYTES - 1));
        end
        last_byte = pdata_o;
        if (line_byte == LINE_BYTES - 1) begin
          line_byte  = 0;
          blank_left = H_BLANK;
          lines_done++;
        end else begin
          line_byte++;
        end
      end else begin
        vectors++;
        if (pdata_o !== last_byte || line_end_o !== 1'b0) begin
          miscompares++;
          $display("FAIL hold: got pdata=%h line_end=%b, want %h/0", pdata_o, line_end_o, last_byte);
        end
        if ((line_byte % 2) == 1 || (line_byte != 0 && !allow_gap)) begin
          miscompares++;
          $display("FAIL gap: de_o low at line byte %0d, want high", line_byte);
        end
      end
    end
  end

  // Present one word on u_dut and wait (bounded) until it is accepted.
  task automatic send(input logic [15:0] w);
    int g = 0;
    pdata_i = w;
    valid_i = 1'b1;
    while (ready_o !== 1'b1 && g < 2000) begin
      @(negedge pclk);
      g++;
    end
    if (ready_o !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: ready_o=%b, want 1", ready_o);
    end else begin
      exp_q.push_back(byte_a(w));
      exp_q.push_back(byte_b(w));
    end
    @(negedge pclk);
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || blank_left != 0 || gap_next || de_o === 1'b1) && g < 6000) begin
      @(negedge pclk);
      g++;
    end
    vectors++;
    if (g >= 6000) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d bytes outstanding, want 0", exp_q.size());
    end
    repeat (2) @(negedge pclk);
  endtask

  task automatic test_reset();
    valid_i = 1'b1; pdata_i = 16'hFFFF;
    one_valid_i = 1'b1; one_pdata_i = 16'hFFFF;
    repeat (3) begin
      @(negedge pclk);
      vectors++;
      if ({pdata_o, de_o, hblank, line_end_o, underrun_o, ready_o} !== 13'h0001 ||
          {one_pdata, one_de, one_hblank, one_line_end, one_underrun, one_ready} !== 13'h0001) begin
        miscompares++;
        $display("FAIL reset_vals: got %h / %h, want 0001", {pdata_o, de_o, hblank, line_end_o, underrun_o, ready_o},
                 {one_pdata, one_de, one_hblank, one_line_end, one_underrun, one_ready});
      end
    end
    rst = 1'b0; valid_i = 1'b0; one_valid_i = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      vectors++;
      if (de_o !== 1'b0 || one_de !== 1'b0 || ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_discard: got de=%b one_de=%b ready=%b, want 0/0/1", de_o, one_de, ready_o);
      end
    end
  endtask

  task automatic test_single_pixel(input logic [15:0] w);
    one_pdata_i = w; one_valid_i = 1'b1;
    vectors++;
    if (one_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL one_ready: got %b, want 1", one_ready);
    end
    @(negedge pclk);
    one_valid_i = 1'b0;
    vectors++;
    if (one_de !== 1'b0) begin
      miscompares++;
      $display("FAIL one_latency: de after write edge got %b, want 0", one_de);
    end
    @(negedge pclk);
    vectors++;
    if ({one_de, one_line_end, one_pdata} !== {1'b1, 1'b0, byte_a(w)}) begin
      miscompares++;
      $display("FAIL one_first: got de=%b le=%b %h, want 1/0 %h", one_de, one_line_end, one_pdata, byte_a(w));
    end
    @(negedge pclk);
    vectors++;
    if ({one_de, one_line_end, one_pdata} !== {1'b1, 1'b1, byte_b(w)}) begin
      miscompares++;
      $display("FAIL one_second: got de=%b le=%b %h, want 1/1 %h", one_de, one_line_end, one_pdata, byte_b(w));
    end
    for (int i = 0; i < H_BLANK; i++) begin
      @(negedge pclk);
      vectors++;
      if (one_hblank !== 1'b1 || one_de !== 1'b0) begin
        miscompares++;
        $display("FAIL one_blank[%0d]: got hb=%b de=%b, want 1/0", i, one_hblank, one_de);
      end
    end
    @(negedge pclk);
    vectors++;
    if (one_hblank !== 1'b0 || one_de !== 1'b0 || one_pdata !== byte_b(w)) begin
      miscompares++;
      $display("FAIL one_idle: got hb=%b de=%b %h, want 0/0 %h", one_hblank, one_de, one_pdata, byte_b(w));
    end
    repeat (2) @(negedge pclk);
  endtask

  task automatic test_full_line();
    int l0 = lines_done;
    for (int i = 0; i < H_ACTIVE; i++) send(16'(i));
    valid_i = 1'b0;
    wait_drain();
    vectors++;
    if (underrun_o !== 1'b0 || lines_done != l0 + 1) begin
      miscompares++;
      $display("FAIL full_line: got underrun=%b lines=%0d, want 0/%0d", underrun_o, lines_done - l0, 1);
    end
  endtask

  task automatic test_underrun();
    int l0 = lines_done;
    allow_gap = 1'b1;
    for (int i = 0; i < 4; i++) send(16'(16'h1000 + i));
    valid_i = 1'b0;
    repeat (12) @(negedge pclk);
    vectors++;
    if (underrun_o !== 1'b1 || de_o !== 1'b0) begin
      miscompares++;
      $display("FAIL underrun_set: got underrun=%b de=%b, want 1/0", underrun_o, de_o);
    end
    for (int i = 4; i < H_ACTIVE; i++) send(16'(16'h1000 + i));
    valid_i = 1'b0;
    wait_drain();
    vectors++;
    if (underrun_o !== 1'b1 || lines_done != l0 + 1) begin
      miscompares++;
      $display("FAIL underrun_sticky: got underrun=%b lines=%0d, want 1/1", underrun_o, lines_done - l0);
    end
    allow_gap = 1'b0;
  endtask

  task automatic test_backpressure();
    int l0 = lines_done;
    int g = 0;
    for (int i = 0; i < H_ACTIVE; i++) send(16'(16'h2000 + i));
    valid_i = 1'b0;
    while (hblank !== 1'b1 && g < 4000) begin
      @(negedge pclk);
      g++;
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      vectors++;
      if (ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_accept[%0d]: got ready=%b, want 1", i, ready_o);
      end
      send(16'(16'h3000 + i));
    end
    pdata_i = 16'(16'h3000 + FIFO_DEPTH);
    valid_i = 1'b1;
    vectors++;
    if (ready_o !== 1'b0 || hblank !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_full: got ready=%b hblank=%b, want 0/1", ready_o, hblank);
    end
    g = 0;
    while (ready_o !== 1'b1 && g < 100) begin
      @(negedge pclk);
      g++;
    end
    vectors++;
    if (ready_o !== 1'b1 || de_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got ready=%b de=%b, want 1/1", ready_o, de_o);
    end
    for (int i = FIFO_DEPTH; i < H_ACTIVE; i++) send(16'(16'h3000 + i));
    valid_i = 1'b0;
    wait_drain();
    vectors++;
    if (lines_done != l0 + 2) begin
      miscompares++;
      $display("FAIL bp_lines: got %0d, want 2", lines_done - l0);
    end
  endtask

  task automatic test_reset_midline();
    int l0;
    for (int i = 0; i < H_ACTIVE && line_byte < 100; i++) send(16'(16'h4000 + i));
    valid_i = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if ({pdata_o, de_o, hblank, line_end_o, underrun_o, ready_o} !== 13'h0001) begin
      miscompares++;
      $display("FAIL midline_reset: got %h, want 0001", {pdata_o, de_o, hblank, line_end_o, underrun_o, ready_o});
    end
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    l0 = lines_done;
    for (int i = 0; i < H_ACTIVE; i++) send(16'(16'h5000 + i));
    valid_i = 1'b0;
    wait_drain();
    vectors++;
    if (lines_done != l0 + 1 || underrun_o !== 1'b0) begin
      miscompares++;
      $display("FAIL fresh_line: got lines=%0d underrun=%b, want 1/0", lines_done - l0, underrun_o);
    end
  endtask

  initial begin
    rst = 1'b1;
    valid_i = 1'b0;
    pdata_i = 16'h0000;
    one_valid_i = 1'b0;
    one_pdata_i = 16'h0000;
    test_reset();
    test_single_pixel(16'hA55A);
    test_single_pixel(16'h1234);
    test_full_line();
    test_underrun();
    test_backpressure();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
